// File: rtl/uart_transmitter.sv
// UART transmit half: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// The requester holds TRANSMITTER_PRIZNAK until the end pulse and must drop it before the next frame.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clc,
  input  logic       res,
  input  logic       TRANSMITTER_PRIZNAK,
  input  logic [7:0] word_transmitter,
  output logic       tx,
  output logic       priznak_end_transmitter,
  output logic       busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_armed;
  logic          r_tx;
  logic          r_end;
  logic          r_busy;

  logic w_bit_done;
  logic w_start;

  assign w_bit_done = (r_baud == BAUD_LAST);
  assign w_start    = (r_state == S_IDLE) && TRANSMITTER_PRIZNAK && r_armed;

  always_ff @(posedge clc) begin
    if (!res) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_armed  <= 1'b1;
      r_tx     <= 1'b1;
      r_end    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // armed re-arms only once the requester has released its level request
      if (!TRANSMITTER_PRIZNAK) r_armed <= 1'b1;
      r_end <= 1'b0;
      if (r_state != S_IDLE && r_state != S_DONE)
        r_baud <= w_bit_done ? '0 : r_baud + BW'(1);

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_START;
            r_armed  <= 1'b0;
            r_shift  <= word_transmitter;
            r_parity <= ^word_transmitter;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_baud   <= '0;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_done) begin
            r_state <= S_STOP;
            r_bit   <= '0;
            r_tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            if (r_bit == STOP_LAST) begin
              r_state <= S_DONE;
              r_bit   <= '0;
              r_end   <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx                      = r_tx;
  assign priznak_end_transmitter = r_end;
  assign busy                    = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances cover no-parity, parity and two-stop-bit frames.
module tb_uart_transmitter;

  logic       clc = 1'b0;
  logic       res;
  logic       reqA, reqB, reqC;
  logic [7:0] wordA, wordB, wordC;
  logic       txA, txB, txC;
  logic       endA, endB, endC;
  logic       busyA, busyB, busyC;

  int checks = 0;
  int errors = 0;

  always #5 clc = ~clc;

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dutA (
    .clc(clc), .res(res), .TRANSMITTER_PRIZNAK(reqA), .word_transmitter(wordA),
    .tx(txA), .priznak_end_transmitter(endA), .busy(busyA));

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dutB (
    .clc(clc), .res(res), .TRANSMITTER_PRIZNAK(reqB), .word_transmitter(wordB),
    .tx(txB), .priznak_end_transmitter(endB), .busy(busyB));

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dutC (
    .clc(clc), .res(res), .TRANSMITTER_PRIZNAK(reqC), .word_transmitter(wordC),
    .tx(txC), .priznak_end_transmitter(endC), .busy(busyC));

  function automatic logic tx_of(input int i);
    case (i)
      0:       return txA;
      1:       return txB;
      default: return txC;
    endcase
  endfunction

  function automatic logic end_of(input int i);
    case (i)
      0:       return endA;
      1:       return endB;
      default: return endC;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0:       return busyA;
      1:       return busyB;
      default: return busyC;
    endcase
  endfunction

  task automatic set_req(input int i, input logic v);
    case (i)
      0:       reqA = v;
      1:       reqB = v;
      default: reqC = v;
    endcase
  endtask

  task automatic set_word(input int i, input logic [7:0] w);
    case (i)
      0:       wordA = w;
      1:       wordB = w;
      default: wordC = w;
    endcase
  endtask

  task automatic step;
    @(posedge clc);
    @(negedge clc);
  endtask

  // Called at a negedge with the instance idle and armed; cycle n is sampled after edge n,
  // where edge 0 is the one that sees the request.
  task automatic send_and_check(input int inst, input logic [7:0] w, input int par, input int stops,
                                input bit hold, input bit change_word, input string name);
    int f;
    int k;
    logic etx, ebusy, eend;
    f = (1 + 8 + par + stops) * 4;
    set_word(inst, w);
    set_req(inst, 1'b1);
    for (int cyc = 1; cyc <= f + 3; cyc++) begin
      step();
      k = (cyc - 1) / 4;
      if (cyc > f)            etx = 1'b1;
      else if (k == 0)        etx = 1'b0;
      else if (k <= 8)        etx = w[k-1];
      else if (k == 9 && par) etx = ^w;
      else                    etx = 1'b1;
      ebusy = (cyc <= f + 1);
      eend  = (cyc == f + 1);
      checks++;
      if (tx_of(inst) !== etx) begin
        errors++;
        $display("FAIL %s tx cycle %0d got %b expected %b", name, cyc, tx_of(inst), etx);
      end
      checks++;
      if (busy_of(inst) !== ebusy) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b expected %b", name, cyc, busy_of(inst), ebusy);
      end
      checks++;
      if (end_of(inst) !== eend) begin
        errors++;
        $display("FAIL %s end cycle %0d got %b expected %b", name, cyc, end_of(inst), eend);
      end
      if (change_word && cyc == 10) set_word(inst, 8'hFF);
      if (!hold && cyc == f + 1) set_req(inst, 1'b0);
    end
  endtask

  task automatic test_reset;
    res = 1'b0;
    reqA = 1'b0; reqB = 1'b0; reqC = 1'b0;
    wordA = 8'h00; wordB = 8'h00; wordC = 8'h00;
    @(negedge clc);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_of(i) !== 1'b1 || busy_of(i) !== 1'b0 || end_of(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst %0d got tx/busy/end %b%b%b expected 100",
                 i, tx_of(i), busy_of(i), end_of(i));
      end
    end
    res = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ((endA | endB | endC | busyA | busyB | busyC) !== 1'b0 || (txA & txB & txC) !== 1'b1) begin
        errors++;
        $display("FAIL reset_release cycle %0d got end %b%b%b busy %b%b%b expected idle",
                 c, endA, endB, endC, busyA, busyB, busyC);
      end
    end
  endtask

  task automatic test_basic_frame;
    send_and_check(0, 8'h55, 0, 1, 1'b0, 1'b0, "basic_55");
  endtask

  task automatic test_hold_off;
    send_and_check(0, 8'hC3, 0, 1, 1'b1, 1'b0, "holdoff_first");
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (txA !== 1'b1 || busyA !== 1'b0 || endA !== 1'b0) begin
        errors++;
        $display("FAIL holdoff_idle cycle %0d got tx/busy/end %b%b%b expected 100", c, txA, busyA, endA);
      end
    end
    reqA = 1'b0;
    step();
    send_and_check(0, 8'h3C, 0, 1, 1'b0, 1'b0, "holdoff_second");
  endtask

  task automatic test_parity;
    send_and_check(1, 8'h07, 1, 1, 1'b0, 1'b0, "parity_07");
    send_and_check(1, 8'h03, 1, 1, 1'b0, 1'b0, "parity_03");
    send_and_check(2, 8'h07, 1, 2, 1'b0, 1'b0, "stop2_07");
  endtask

  task automatic test_latching;
    send_and_check(0, 8'hA5, 0, 1, 1'b0, 1'b1, "latch_A5");
  endtask

  task automatic test_reset_mid_frame;
    bit seen_end;
    wordA = 8'h5A;
    reqA  = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) step();
    res  = 1'b0;
    reqA = 1'b0;
    step();
    checks++;
    if (txA !== 1'b1 || busyA !== 1'b0 || endA !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got tx/busy/end %b%b%b expected 100", txA, busyA, endA);
    end
    res = 1'b1;
    seen_end = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (endA === 1'b1 || busyA === 1'b1) seen_end = 1'b1;
    end
    checks++;
    if (seen_end !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_end got activity %b expected %b", seen_end, 1'b0);
    end
    send_and_check(0, 8'h96, 0, 1, 1'b0, 1'b0, "after_midreset");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_hold_off();
    test_parity();
    test_latching();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit half of the UART: accepts a byte from the receiver/transmitter coupling block via the TRANSMITTER_PRIZNAK / priznak_end_transmitter handshake. It shifts the byte out as an asynchronous 8-bit frame on the tx line. Frame format is start bit, 8 data bits LSB first, optional even parity, and 1 or 2 stop bits. It sits between the coupling block and the board TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 5208, clc cycles per bit (50 MHz / 9600 baud); legal range ≥ 2
- PARITY_EN, 0, 1 = insert even-parity bit after data, 0 = none
- STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
- clc  input  1  system clock; everything on its rising edge
- res  input  1  reset, synchronous, active-low
- TRANSMITTER_PRIZNAK  input  1  transmit request, level, held by requester until end pulse
- word_transmitter  input  8  byte to send; sampled only at frame start
- tx  output  1  serial line, idle high
- priznak_end_transmitter  output  1  one-cycle pulse: frame complete
- busy  output  1  high while a frame is in progress, including the DONE cycle

## Operation
- Reset (res=0 at a clc edge) forces:
  - tx=1, busy=0, priznak_end_transmitter=0
  - state IDLE, bit/baud counters 0, shift register 0
  - armed=1
- Reset mid-frame aborts the frame: no end pulse, no partial completion.
- armed flag:
  - Set at any edge where TRANSMITTER_PRIZNAK=0.
  - Cleared at frame start.
  - Prevents re-sending while the requester still holds the request after the end pulse.
- Start condition: state IDLE & TRANSMITTER_PRIZNAK=1 & armed=1.
  - At that edge, word_transmitter is latched into the shift register and parity is computed as XOR of the latched byte.
  - Later changes on word_transmitter have no effect on the frame.
- States, each bit held CLKS_PER_BIT cycles, counted by a baud counter of width $clog2(CLKS_PER_BIT) that wraps to 0 on each bit boundary:
  - IDLE: tx=1, waits for start condition → START.
  - START: tx=0 → DATA.
  - DATA: tx = shift_reg[0]; shift right at each bit boundary; after bit 7 → PARITY if PARITY_EN else STOP.
  - PARITY: tx = even parity (1 when the byte has an odd number of ones) → STOP.
  - STOP: tx=1 for STOP_BITS bit periods → DONE.
  - DONE: exactly one cycle; tx=1, priznak_end_transmitter=1 → IDLE.
- Requests arriving while busy are ignored. The requester is expected to hold off until the end pulse.
- Bit counter is 3 bits and counts 0..7 in DATA; it counts stop bits in STOP.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Start edge E (start condition sampled):
  - tx=0 and busy=1 from cycle E+1.
  - Bit k of the frame (k=0 start) occupies cycles E+1+k·CLKS_PER_BIT … E+(k+1)·CLKS_PER_BIT.
- Frame length is F = (1+8+PARITY_EN+STOP_BITS)·CLKS_PER_BIT cycles.
- End pulse and busy:
  - priznak_end_transmitter=1 in cycle E+F+1 only.
  - busy=1 for cycles E+1 … E+F+1, then 0.
- Earliest next start edge is E+F+2, and only if armed was set, i.e. the requester dropped its request for ≥1 cycle.
- Back-to-back requester handshake: the requester drops its request on the edge sampling the end pulse. It re-raises no earlier than the following edge. The gap between frames on tx is ≥ 1 cycle of idle high beyond the stop bits.
- Reset takes effect at the first clc edge with res=0. Outputs reach their reset values in the following cycle.

## Test plan
- Reset: hold res=0 for 2 edges mid-idle → tx=1, busy=0, priznak_end_transmitter=0; no pulse when res released with TRANSMITTER_PRIZNAK=0.
- Basic frame:
  - Setup: CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1, word 0x55, request at edge 0.
  - tx: 0 cycles 1–4; data 1,0,1,0,1,0,1,0 in 4-cycle groups over cycles 5–36; 1 for cycles 37–40.
  - End pulse in cycle 41 only; busy 1 for cycles 1–41.
- Hold-off: after the end pulse, keep request high 10 more cycles → no new frame (tx stays 1). Drop for 1 cycle, raise again → new frame starts; next end pulse at the expected offset.
- Parity, PARITY_EN=1, CLKS_PER_BIT=4:
  - word 0x07 → parity bit 1 at cycles 37–40, end pulse cycle 45.
  - word 0x03 → parity bit 0.
  - STOP_BITS=2 → stop high 8 cycles, pulse 4 cycles later.
- Latching: change word_transmitter from 0xA5 to 0xFF at cycle 10 of an 0xA5 frame → serialized bits still match 0xA5 (1,0,1,0,0,1,0,1 LSB first).
- Reset mid-frame:
  - Assert res=0 for one edge during data bit 3 → next cycle tx=1, busy=0, and no end pulse ever appears for that frame.
  - A fresh request afterwards sends a full, correct frame.
